// File: rtl/tcb_lite_lib_register_response_pkg.sv
// TCB-Lite shared constants: default bus widths, status width and the
// request byte-enable/size field width helper.
package tcb_lite_lib_register_response_pkg;

  localparam int unsigned TCB_DAT_DEF = 32;
  localparam int unsigned TCB_ADR_DEF = 32;
  localparam int unsigned TCB_STS_W   = 1;

  // byte-enable width: one bit per data byte in mode 0, else a log2 size field
  function automatic int unsigned tcb_ben_w(input int unsigned dat, input int unsigned mod);
    if (mod == 0) return dat / 8;
    return (dat / 8 > 1) ? $clog2(dat / 8) : 1;
  endfunction

endpackage

// File: rtl/tcb_lite_lib_register_response_if.sv
// TCB-Lite bus interface. clk/rst ride on the interface so every device on
// the bus shares one clock and one synchronous active-high reset.
// DLY is the fixed request-to-response latency in cycles.
interface tcb_lite_if
  import tcb_lite_lib_register_response_pkg::*;
#(
  parameter int unsigned DAT = TCB_DAT_DEF,
  parameter int unsigned ADR = TCB_ADR_DEF,
  parameter int unsigned MOD = 0,
  parameter int unsigned DLY = 1
)(
  input logic clk,
  input logic rst
);

  localparam int unsigned BEN = tcb_ben_w(DAT, MOD);

  typedef struct packed {
    logic           wen;
    logic [ADR-1:0] adr;
    logic [BEN-1:0] ben;
    logic [DAT-1:0] wdt;
  } req_t;

  typedef struct packed {
    logic [DAT-1:0]       rdt;
    logic [TCB_STS_W-1:0] sts;
    logic                 err;
  } rsp_t;

  logic vld;
  logic rdy;
  req_t req;
  rsp_t rsp;

  // manager drives the request, subordinate answers
  modport man (input clk, rst, output vld, req, input  rdy, rsp);
  modport sub (input clk, rst, input  vld, req, output rdy, rsp);

endinterface

// File: rtl/tcb_lite_lib_register_response_stage.sv
// One response register stage: {vld, rd} flags plus rdt/sts/err data.
// Build option TCB_LITE_LIB_REGISTER_RESPONSE_GATE_EN: when defined, data
// loads only for valid slots (rdt only for reads) to cut toggling;
// otherwise all data loads every cycle.
module tcb_lite_lib_register_response_stage
  import tcb_lite_lib_register_response_pkg::*;
#(
  parameter int unsigned DAT = TCB_DAT_DEF,
  parameter int unsigned STS = TCB_STS_W
)(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_vld,
  input  logic           i_rd,
  input  logic [DAT-1:0] i_rdt,
  input  logic [STS-1:0] i_sts,
  input  logic           i_err,
  output logic           o_vld,
  output logic           o_rd,
  output logic [DAT-1:0] o_rdt,
  output logic [STS-1:0] o_sts,
  output logic           o_err
);

  logic           r_vld, r_rd;
  logic [DAT-1:0] r_rdt;
  logic [STS-1:0] r_sts;
  logic           r_err;

  // slot flags: cleared by reset so in-flight responses are dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= 1'b0;
      r_rd  <= 1'b0;
    end else begin
      r_vld <= i_vld;
      r_rd  <= i_rd;
    end
  end

`ifdef TCB_LITE_LIB_REGISTER_RESPONSE_GATE_EN
  // status/error captured only for real response slots
  always_ff @(posedge i_clk) begin
    if (i_vld) begin
      r_sts <= i_sts;
      r_err <= i_err;
    end
  end

  // read data captured only for read slots; writes keep the previous value
  always_ff @(posedge i_clk) begin
    if (i_vld & i_rd) r_rdt <= i_rdt;
  end
`else
  // data follows the input every cycle; meaningful only in valid slots
  always_ff @(posedge i_clk) begin
    r_rdt <= i_rdt;
    r_sts <= i_sts;
    r_err <= i_err;
  end
`endif

  assign o_vld = r_vld;
  assign o_rd  = r_rd;
  assign o_rdt = r_rdt;
  assign o_sts = r_sts;
  assign o_err = r_err;

endmodule

// File: rtl/tcb_lite_lib_register_response.sv
// Adds REG_NUM register stages on the TCB-Lite response path; the request
// path is a plain wire-through. The subordinate-side latency is therefore
// man.DLY + REG_NUM.
// Build option TCB_LITE_LIB_REGISTER_RESPONSE_GATE_EN: gated data loads in
// the stages (see the stage module).
module tcb_lite_lib_register_response
  import tcb_lite_lib_register_response_pkg::*;
#(
  parameter int unsigned REG_NUM = 1
)(
  tcb_lite_if.sub sub,
  tcb_lite_if.man man
);

  localparam int DAT  = int'(sub.DAT);
  localparam int MDLY = int'(man.DLY);

`ifndef ALTERA_RESERVED_QIS
  if (sub.DAT != man.DAT) begin : g_chk_dat
    $error("sub.DAT must equal man.DAT");
  end
  if (sub.ADR != man.ADR) begin : g_chk_adr
    $error("sub.ADR must equal man.ADR");
  end
  if (sub.MOD != man.MOD) begin : g_chk_mod
    $error("sub.MOD must equal man.MOD");
  end
  if (sub.DLY != man.DLY + REG_NUM) begin : g_chk_dly
    $error("sub.DLY must equal man.DLY + REG_NUM");
  end
  if (REG_NUM < 1 || REG_NUM > 4) begin : g_chk_reg
    $error("REG_NUM must be 1..4");
  end
`endif

  // request path is combinational; no buffering
  assign man.vld = sub.vld;
  assign man.req = sub.req;
  assign sub.rdy = man.rdy;

  logic w_trn, w_trn_rd;
  logic w_rv0, w_rr0;

  assign w_trn    = man.vld & man.rdy;
  assign w_trn_rd = w_trn & ~man.req.wen;

  if (MDLY == 0) begin : g_dly0
    assign w_rv0 = w_trn;
    assign w_rr0 = w_trn_rd;
  end else begin : g_dly
    logic [MDLY-1:0] r_vld_pipe, r_rd_pipe;

    // age each transfer's {valid, read} flags until the man response lands
    always_ff @(posedge sub.clk) begin
      if (sub.rst) begin
        r_vld_pipe <= '0;
        r_rd_pipe  <= '0;
      end else begin
        r_vld_pipe[0] <= w_trn;
        r_rd_pipe[0]  <= w_trn_rd;
        for (int i = 1; i < MDLY; i++) begin
          r_vld_pipe[i] <= r_vld_pipe[i-1];
          r_rd_pipe[i]  <= r_rd_pipe[i-1];
        end
      end
    end

    assign w_rv0 = r_vld_pipe[MDLY-1];
    assign w_rr0 = r_rd_pipe[MDLY-1];
  end

  // index 0 is the man-side response, index REG_NUM the sub-side one
  logic [REG_NUM:0]                w_vld, w_rd, w_err;
  logic [REG_NUM:0][DAT-1:0]       w_rdt;
  logic [REG_NUM:0][TCB_STS_W-1:0] w_sts;

  assign w_vld[0] = w_rv0;
  assign w_rd[0]  = w_rr0;
  assign w_rdt[0] = man.rsp.rdt;
  assign w_sts[0] = man.rsp.sts;
  assign w_err[0] = man.rsp.err;

  for (genvar k = 0; k < REG_NUM; k++) begin : g_stage
    tcb_lite_lib_register_response_stage #(
      .DAT (DAT),
      .STS (TCB_STS_W)
    ) u_stage (
      .i_clk (sub.clk),
      .i_rst (sub.rst),
      .i_vld (w_vld[k]),
      .i_rd  (w_rd[k]),
      .i_rdt (w_rdt[k]),
      .i_sts (w_sts[k]),
      .i_err (w_err[k]),
      .o_vld (w_vld[k+1]),
      .o_rd  (w_rd[k+1]),
      .o_rdt (w_rdt[k+1]),
      .o_sts (w_sts[k+1]),
      .o_err (w_err[k+1])
    );
  end

  // the bus has no response-valid wire; slot timing is implied by sub.DLY
  logic w_unused;
  assign w_unused = w_rd[REG_NUM];

  assign sub.rsp.rdt = w_rdt[REG_NUM];
  assign sub.rsp.sts = w_sts[REG_NUM];
  assign sub.rsp.err = w_err[REG_NUM];

endmodule

// File: tb/tb_tcb_lite_lib_register_response.sv
// Bench for the response register: config A (man.DLY=1, REG_NUM=1) and
// config B (man.DLY=0, REG_NUM=3) driven by the same request stream.
// A small ROM-backed subordinate model answers on the man side; expected
// sub-side responses are queued at issue time and checked by a monitor.
module tb_tcb_lite_lib_register_response;

  typedef struct packed { logic [31:0] rdt; logic sts; logic err; } trsp_t;
  typedef struct { int due; bit rd; logic [31:0] rdt; logic sts; logic err; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  exp_t        qa[$], qb[$];
  logic [31:0] rom [16];
  bit          prev_trn = 1'b0;
  logic        prev_wen = 1'b0;
  logic [31:0] prev_adr = '0;
  logic [31:0] last_a = '0, last_b = '0;
  bit          hold_a = 1'b0, hold_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcb_lite_if #(.DAT(32), .ADR(32), .MOD(0), .DLY(2)) sub_a (.clk(clk), .rst(rst));
  tcb_lite_if #(.DAT(32), .ADR(32), .MOD(0), .DLY(1)) man_a (.clk(clk), .rst(rst));
  tcb_lite_if #(.DAT(32), .ADR(32), .MOD(0), .DLY(3)) sub_b (.clk(clk), .rst(rst));
  tcb_lite_if #(.DAT(32), .ADR(32), .MOD(0), .DLY(0)) man_b (.clk(clk), .rst(rst));

  tcb_lite_lib_register_response #(.REG_NUM(1)) dut_a (.sub(sub_a), .man(man_a));
  tcb_lite_lib_register_response #(.REG_NUM(3)) dut_b (.sub(sub_b), .man(man_b));

  // subordinate device: reads return ROM words, writes return junk data,
  // sts is address parity, err flags the out-of-range window (adr bit 9)
  function automatic trsp_t rsp_of(input logic wen, input logic [31:0] adr);
    trsp_t r;
    r.rdt = wen ? ~rom[adr[5:2]] : rom[adr[5:2]];
    r.sts = ^adr[5:2];
    r.err = adr[9];
    return r;
  endfunction

  task automatic drive(input bit v, input bit wen, input logic [31:0] adr,
                       input bit rdy, input bit r);
    trsp_t junk;
    bit    trn;
    exp_t  e;
    @(posedge clk); #1;
    junk = {$urandom, 2'($urandom_range(3, 0))};
    man_a.rsp = prev_trn ? rsp_of(prev_wen, prev_adr) : junk;
    rst = r;
    sub_a.vld     = v;
    sub_a.req.wen = wen;
    sub_a.req.adr = adr;
    sub_a.req.ben = 4'hF;
    sub_a.req.wdt = $urandom;
    sub_b.vld     = v;
    sub_b.req     = sub_a.req;
    man_a.rdy = rdy;
    man_b.rdy = rdy;
    trn = v & rdy;
    man_b.rsp = trn ? rsp_of(wen, adr) : junk;
    if (trn) begin
      e.due = cyc + 2;
      e.rd  = !wen;
      e.rdt = rom[adr[5:2]];
      e.sts = ^adr[5:2];
      e.err = adr[9];
      qa.push_back(e);
      e.due = cyc + 3;
      qb.push_back(e);
    end
    prev_trn = trn;
    prev_wen = wen;
    prev_adr = adr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic mon(inout exp_t q[$], inout logic [31:0] last, inout bit hold,
                     input string nm, input logic vld, input logic [31:0] rdt,
                     input logic sts, input logic err);
    exp_t e;
    bit   want;
    want = (q.size() != 0) && (q[0].due == cyc);
    n_tests++;
    if (vld !== want) begin
      n_fail++;
      $display("FAIL %s slot @%0d: vld=%0b expected %0b", nm, cyc, vld, want);
    end
    if (want) begin
      e = q.pop_front();
      if (vld === 1'b1) begin
        n_tests++;
        if (sts !== e.sts || err !== e.err) begin
          n_fail++;
          $display("FAIL %s sts/err @%0d: got %0b/%0b expected %0b/%0b",
                   nm, cyc, sts, err, e.sts, e.err);
        end
        if (e.rd) begin
          n_tests++;
          if (rdt !== e.rdt) begin
            n_fail++;
            $display("FAIL %s rdt @%0d: got %h expected %h", nm, cyc, rdt, e.rdt);
          end
          last = e.rdt;
          hold = 1'b1;
        end
`ifdef TCB_LITE_LIB_REGISTER_RESPONSE_GATE_EN
        else if (hold) begin
          n_tests++;
          if (rdt !== last) begin
            n_fail++;
            $display("FAIL %s rdt_hold @%0d: got %h expected %h", nm, cyc, rdt, last);
          end
        end
`endif
      end
    end
    // anything still queued during reset is dropped by the design
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(qa, last_a, hold_a, "A", dut_a.w_vld[1], sub_a.rsp.rdt, sub_a.rsp.sts[0], sub_a.rsp.err);
      mon(qb, last_b, hold_b, "B", dut_b.w_vld[3], sub_b.rsp.rdt, sub_b.rsp.sts[0], sub_b.rsp.err);
      n_tests++;
      if (man_a.vld !== sub_a.vld || man_a.req !== sub_a.req || sub_a.rdy !== man_a.rdy) begin
        n_fail++;
        $display("FAIL pass_a @%0d: man.vld=%0b sub.rdy=%0b expected %0b/%0b",
                 cyc, man_a.vld, sub_a.rdy, sub_a.vld, man_a.rdy);
      end
      n_tests++;
      if (man_b.vld !== sub_b.vld || man_b.req !== sub_b.req || sub_b.rdy !== man_b.rdy) begin
        n_fail++;
        $display("FAIL pass_b @%0d: man.vld=%0b sub.rdy=%0b expected %0b/%0b",
                 cyc, man_b.vld, sub_b.rdy, sub_b.vld, man_b.rdy);
      end
    end
  end

  initial begin
    logic [31:0] adr;
    sub_a.vld = 1'b0; sub_a.req = '0;
    sub_b.vld = 1'b0; sub_b.req = '0;
    man_a.rdy = 1'b0; man_b.rdy = 1'b0;
    man_a.rsp = '0;   man_b.rsp = '0;
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    rom[4]  = 32'hDEADBEEF;
    rom[8]  = 32'h1;
    rom[9]  = 32'h2;
    rom[10] = 32'h3;

    repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    mon_en = 1'b1;
    repeat (2) idle();

    // single read
    drive(1'b1, 1'b0, 32'h10, 1'b1, 1'b0);
    repeat (4) idle();

    // back-to-back reads
    drive(1'b1, 1'b0, 32'h20, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h24, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h28, 1'b1, 1'b0);
    repeat (4) idle();

    // write to the error window
    drive(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
    repeat (4) idle();

    // backpressure: three stalled cycles then accept
    repeat (3) drive(1'b1, 1'b0, 32'h14, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h14, 1'b1, 1'b0);
    repeat (5) idle();

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      adr = (32'($urandom_range(1, 0)) << 9) | (32'($urandom_range(15, 0)) << 2);
      drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, adr,
            $urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0);
    end
    repeat (5) idle();

    // reset one cycle after a read, then a clean read
    drive(1'b1, 1'b0, 32'h30, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 32'h34, 1'b1, 1'b0);
    repeat (5) idle();

    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending A=%0d B=%0d expected 0/0", qa.size(), qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
